// File: rtl/dd_adpcm_pkg.sv
// Shared types and tables for the Double Dragon ADPCM voice.
// Contents:
//   state_e   player state (idle / playing)
//   PRESCALE  cen_oki pulses per output sample (375 kHz / 48 = 7.8125 kHz)
//   STEP      OKI ADPCM step-size table, indexed 0..48
//   ADJ       step-index adjustment per nibble magnitude n[2:0]
package dd_adpcm_pkg;

    typedef enum logic {StIdle, StPlay} state_e;

    localparam int unsigned PRESCALE = 48;

    localparam logic [10:0] STEP [49] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
        11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
        11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
        11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
        11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
        11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
        11'd1552
    };

    localparam logic signed [4:0] ADJ [8] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

endpackage

// File: rtl/dd_adpcm_dec.sv
// OKI 4-bit ADPCM nibble decoder (MSM5205 core).
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   en_i    decode nib_i this cycle
//   clr_i   clear signal and step index (wins over en_i)
//   nib_i   ADPCM nibble, bit 3 = sign
//   snd_o   registered signed 12-bit signal
module dd_adpcm_dec
    import dd_adpcm_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [3:0]         nib_i,
    output logic signed [11:0] snd_o
);

    logic signed [11:0] signal_q, signal_d;
    logic [5:0]         idx_q, idx_d;
    logic [12:0]        step_val, delta;
    logic signed [13:0] sig_ext, sum;
    logic signed [6:0]  idx_sum;
    logic signed [4:0]  adj;

    always_comb begin
        step_val = {2'b00, STEP[idx_q]};
        // Worst case 1552/8 + 1552 + 776 + 388 = 2910, fits 13 bits.
        delta = (step_val >> 3)
              + (nib_i[2] ? step_val        : 13'd0)
              + (nib_i[1] ? (step_val >> 1) : 13'd0)
              + (nib_i[0] ? (step_val >> 2) : 13'd0);
        sig_ext = {{2{signal_q[11]}}, signal_q};
        sum = nib_i[3] ? sig_ext - $signed({1'b0, delta}) : sig_ext + $signed({1'b0, delta});

        adj     = ADJ[nib_i[2:0]];
        idx_sum = $signed({1'b0, idx_q}) + $signed({{2{adj[4]}}, adj});

        signal_d = signal_q;
        idx_d    = idx_q;
        if (clr_i) begin
            signal_d = '0;
            idx_d    = '0;
        end else if (en_i) begin
            if (sum > 14'sd2047) begin
                signal_d = 12'sd2047;
            end else if (sum < -14'sd2048) begin
                signal_d = -12'sd2048;
            end else begin
                signal_d = sum[11:0];
            end
            if (idx_sum < 7'sd0) begin
                idx_d = 6'd0;
            end else if (idx_sum > 7'sd48) begin
                idx_d = 6'd48;
            end else begin
                idx_d = idx_sum[5:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            signal_q <= '0;
            idx_q    <= '0;
        end else begin
            signal_q <= signal_d;
            idx_q    <= idx_d;
        end
    end

    assign snd_o = signal_q;

endmodule

// File: rtl/dd_adpcm_player.sv
// One ADPCM voice of the Double Dragon sound board: CPU register file,
// sample ROM address counter, 375 kHz / 48 sample prescaler and decoder.
// Ports:
//   clk_i       system clock (24 MHz)
//   rst_i       synchronous active-high reset
//   cpu_cen_i   CPU bus-cycle enable qualifying writes
//   cen_oki_i   375 kHz enable, one clk wide
//   cpu_dout_i  CPU write data
//   cpu_ab_i    register select: 0 stop, 1 play, 2 start page, 3 end page
//   cs_i        write strobe
//   rom_addr_o  sample ROM byte address
//   rom_cs_o    ROM request, doubles as busy status
//   rom_data_i  ROM data
//   rom_ok_i    rom_data_i valid for rom_addr_o
//   snd_o       signed decoded sample
//   sample_o    one-clk pulse when snd_o updates
module dd_adpcm_player
    import dd_adpcm_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cpu_cen_i,
    input  logic               cen_oki_i,
    input  logic [7:0]         cpu_dout_i,
    input  logic [1:0]         cpu_ab_i,
    input  logic               cs_i,
    output logic [15:0]        rom_addr_o,
    output logic               rom_cs_o,
    input  logic [7:0]         rom_data_i,
    input  logic               rom_ok_i,
    output logic signed [11:0] snd_o,
    output logic               sample_o
);

    state_e      state_q, state_d;
    logic [15:0] pos_q, pos_d, end_q, end_d, pos_inc;
    logic        nib_hi_q, nib_hi_d;
    logic [7:0]  latch_q;
    logic [5:0]  presc_q, presc_d;
    logic        sample_q;
    logic        wr_en, tick, play_tick, dec_clr;
    logic [3:0]  nib;

    assign wr_en     = cs_i & cpu_cen_i;
    assign tick      = cen_oki_i && (presc_q == 6'(PRESCALE - 1));
    assign play_tick = tick && (state_q == StPlay);
    assign pos_inc   = pos_q + 16'd1;
    assign nib       = nib_hi_q ? latch_q[7:4] : latch_q[3:0];

    // Prescaler free-runs even when idle so the sample grid never shifts.
    always_comb begin
        presc_d = presc_q;
        if (cen_oki_i) begin
            presc_d = tick ? 6'd0 : presc_q + 6'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        end_d    = end_q;
        nib_hi_d = nib_hi_q;
        dec_clr  = 1'b0;

        if (play_tick) begin
            nib_hi_d = ~nib_hi_q;
            if (!nib_hi_q) begin
                pos_d = pos_inc;
                if (pos_inc == end_q || pos_q == 16'hFFFF) begin
                    state_d = StIdle;
                    dec_clr = 1'b1;
                end
            end
        end

        // CPU writes take priority over the playback update of the same cycle.
        if (wr_en) begin
            unique case (cpu_ab_i)
                2'd0: begin
                    state_d = StIdle;
                    dec_clr = 1'b1;
                end
                2'd1: begin
                    state_d  = StPlay;
                    nib_hi_d = 1'b1;
                end
                2'd2: pos_d = {cpu_dout_i[6:0], 9'd0};
                2'd3: end_d = {cpu_dout_i[6:0], 9'd0};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            pos_q    <= '0;
            end_q    <= '0;
            nib_hi_q <= 1'b1;
            latch_q  <= '0;
            presc_q  <= '0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            end_q    <= end_d;
            nib_hi_q <= nib_hi_d;
            presc_q  <= presc_d;
            sample_q <= play_tick;
            if (rom_ok_i && state_q == StPlay) begin
                latch_q <= rom_data_i;
            end
        end
    end

    dd_adpcm_dec u_dec (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (play_tick),
        .clr_i (dec_clr),
        .nib_i (nib),
        .snd_o (snd_o)
    );

    assign rom_addr_o = pos_q;
    assign rom_cs_o   = (state_q == StPlay);
    assign sample_o   = sample_q;

endmodule

// File: tb/tb_dd_adpcm_player.sv
module tb_dd_adpcm_player;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cpu_cen = 1'b1;
    logic               cen_oki = 1'b0;
    logic [7:0]         cpu_dout = '0;
    logic [1:0]         cpu_ab = '0;
    logic               cs = 1'b0;
    logic [15:0]        rom_addr;
    logic               rom_cs;
    logic [7:0]         rom_data;
    logic               rom_ok = 1'b1;
    logic signed [11:0] snd;
    logic               sample;

    logic [7:0] rom [65536];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    dd_adpcm_player dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cpu_cen_i  (cpu_cen),
        .cen_oki_i  (cen_oki),
        .cpu_dout_i (cpu_dout),
        .cpu_ab_i   (cpu_ab),
        .cs_i       (cs),
        .rom_addr_o (rom_addr),
        .rom_cs_o   (rom_cs),
        .rom_data_i (rom_data),
        .rom_ok_i   (rom_ok),
        .snd_o      (snd),
        .sample_o   (sample)
    );

    int total = 0;
    int bad = 0;
    int cen_pct = 100;
    int ok_pct = 100;

    // Reference model state, in the terms of the datasheet behaviour.
    bit          m_play, m_hi, m_sample;
    logic [15:0] m_pos, m_end;
    logic [7:0]  m_latch;
    int          m_sig, m_idx, m_cen;

    int step_tab [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73,
                          80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279,
                          307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060,
                          1166, 1282, 1411, 1552};
    int adj_tab [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    task automatic decode(input int n, inout int sig, inout int idx);
        int s, d;
        s = step_tab[idx];
        d = s / 8 + (((n & 4) != 0) ? s : 0) + (((n & 2) != 0) ? s / 2 : 0)
            + (((n & 1) != 0) ? s / 4 : 0);
        sig = ((n & 8) != 0) ? sig - d : sig + d;
        if (sig > 2047) sig = 2047;
        if (sig < -2048) sig = -2048;
        idx = idx + adj_tab[n & 7];
        if (idx < 0) idx = 0;
        if (idx > 48) idx = 48;
    endtask

    task automatic model_step();
        bit          tick, was_play;
        logic [7:0]  rd;
        int          n;
        if (rst) begin
            m_play = 0; m_hi = 1; m_sample = 0; m_pos = '0; m_end = '0;
            m_latch = '0; m_sig = 0; m_idx = 0; m_cen = 0;
            return;
        end
        rd = rom[m_pos];
        was_play = m_play;
        tick = cen_oki && (m_cen == 47);
        if (cen_oki) m_cen = (m_cen + 1) % 48;
        m_sample = tick && m_play;
        if (tick && m_play) begin
            n = m_hi ? int'(m_latch[7:4]) : int'(m_latch[3:0]);
            decode(n, m_sig, m_idx);
            if (!m_hi) begin
                if (m_pos == 16'hFFFF || m_pos + 16'd1 == m_end) begin
                    m_play = 0; m_sig = 0; m_idx = 0;
                end
                m_pos = m_pos + 16'd1;
            end
            m_hi = !m_hi;
        end
        if (rom_ok && was_play) m_latch = rd;
        if (cs && cpu_cen) begin
            case (cpu_ab)
                2'd0: begin m_play = 0; m_sig = 0; m_idx = 0; end
                2'd1: begin m_play = 1; m_hi = 1; end
                2'd2: m_pos = {cpu_dout[6:0], 9'd0};
                default: m_end = {cpu_dout[6:0], 9'd0};
            endcase
        end
    endtask

    task automatic step();
        cen_oki = (cen_pct >= 100) ? 1'b1 : ($urandom_range(99) < cen_pct);
        rom_ok  = (ok_pct >= 100) ? 1'b1 : ($urandom_range(99) < ok_pct);
        model_step();
        @(posedge clk);
        #1;
        total++;
        if (rom_cs !== m_play || rom_addr !== m_pos || snd !== 12'(m_sig)
            || sample !== m_sample) begin
            bad++;
            $display("FAIL cycle t=%0t: cs=%0b addr=%h snd=%0d smp=%0b want cs=%0b addr=%h snd=%0d smp=%0b",
                     $time, rom_cs, rom_addr, snd, sample, m_play, m_pos, 12'(m_sig), m_sample);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] ab, input logic [7:0] d);
        cs = 1'b1; cpu_cen = 1'b1; cpu_ab = ab; cpu_dout = d;
        step();
        cs = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Steps until n sample pulses are seen or the cycle bound expires.
    task automatic run_samples(input int n, input int bound, output int got);
        got = 0;
        for (int c = 0; c < bound && got < n; c++) begin
            step();
            if (sample) got++;
        end
    endtask

    typedef struct {
        logic [7:0] b;
        int         s1;
        int         s2;
    } vec_t;
    vec_t vt [6];

    initial begin
        int got, cnt, last, maxa, min_iv, max_iv, saved;

        for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom);

        // Reset state and idle prescaler activity.
        do_reset();
        check("reset rom_cs", int'(rom_cs), 0);
        check("reset rom_addr", int'(rom_addr), 0);
        check("reset snd", int'(snd), 0);
        check("reset sample", int'(sample), 0);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (sample) cnt++;
        end
        check("idle samples", cnt, 0);

        // First two decoded samples from reset for a repeated byte.
        vt[0] = '{8'h77, 30, 93};
        vt[1] = '{8'hFF, -30, -93};
        vt[2] = '{8'h00, 2, 4};
        vt[3] = '{8'h80, -2, 0};
        vt[4] = '{8'h4C, 18, -3};
        vt[5] = '{8'h12, 6, 16};
        for (int i = 0; i < 6; i++) begin
            for (int a = 0; a < 16; a++) rom[a] = vt[i].b;
            do_reset();
            wr(2'd3, 8'h7F);
            wr(2'd2, 8'h00);
            wr(2'd1, 8'h00);
            run_samples(1, 200, got);
            check($sformatf("vec%0d first", i), int'(snd), vt[i].s1);
            run_samples(1, 200, got);
            check($sformatf("vec%0d second", i), int'(snd), vt[i].s2);
        end

        // Saturation both ways.
        for (int a = 0; a < 64; a++) rom[a] = 8'h77;
        do_reset();
        wr(2'd3, 8'h7F); wr(2'd2, 8'h00); wr(2'd1, 8'h00);
        run_samples(40, 40 * 48 + 100, got);
        check("sat pos count", got, 40);
        check("sat pos", int'(snd), 2047);
        run_samples(4, 300, got);
        check("sat pos hold", int'(snd), 2047);
        for (int a = 0; a < 64; a++) rom[a] = 8'hFF;
        do_reset();
        wr(2'd3, 8'h7F); wr(2'd2, 8'h00); wr(2'd1, 8'h00);
        run_samples(40, 40 * 48 + 100, got);
        check("sat neg", int'(snd), -2048);

        // Full page range 0x0200..0x03FF.
        do_reset();
        wr(2'd2, 8'h01);
        wr(2'd3, 8'h02);
        wr(2'd1, 8'h00);
        check("play addr", int'(rom_addr), 16'h0200);
        check("play cs", int'(rom_cs), 1);
        cnt = 0; last = -1; maxa = 0; min_iv = 1 << 30; max_iv = 0;
        for (int c = 0; c < 60000 && rom_cs; c++) begin
            if (int'(rom_addr) > maxa) maxa = int'(rom_addr);
            step();
            if (sample) begin
                if (last >= 0) begin
                    if (c - last < min_iv) min_iv = c - last;
                    if (c - last > max_iv) max_iv = c - last;
                end
                last = c;
                cnt++;
            end
        end
        check("range ended", int'(rom_cs), 0);
        check("range samples", cnt, 1024);
        check("range max addr", maxa, 16'h03FF);
        check("range min period", min_iv, 48);
        check("range max period", max_iv, 48);

        // Stop mid-play, then resume from the current position.
        do_reset();
        wr(2'd3, 8'h7F); wr(2'd2, 8'h00); wr(2'd1, 8'h00);
        run_samples(21, 21 * 48 + 100, got);
        wr(2'd0, 8'h00);
        check("stop cs", int'(rom_cs), 0);
        check("stop snd", int'(snd), 0);
        saved = int'(rom_addr);
        for (int c = 0; c < 5; c++) step();
        wr(2'd1, 8'h00);
        check("resume addr", int'(rom_addr), saved);
        check("resume cs", int'(rom_cs), 1);
        run_samples(4, 300, got);
        check("resume samples", got, 4);

        // ROM never ready: timing unaffected.
        do_reset();
        ok_pct = 0;
        wr(2'd3, 8'h7F); wr(2'd2, 8'h00); wr(2'd1, 8'h00);
        cnt = 0;
        for (int c = 0; c < 20 * 48; c++) begin
            step();
            if (sample) cnt++;
        end
        check("rom_ok low samples", cnt, 20);
        ok_pct = 100;

        // Randomised traffic: sparse cen_oki, flaky ROM, occasional register writes.
        cen_pct = 60;
        ok_pct = 70;
        for (int r = 0; r < 3; r++) begin
            wr(2'd2, 8'($urandom_range(127)));
            wr(2'd3, 8'($urandom_range(127)));
            wr(2'd1, 8'h00);
            for (int c = 0; c < 2000; c++) begin
                if ($urandom_range(299) == 0) begin
                    cs = 1'b1;
                    cpu_cen = 1'($urandom_range(1));
                    cpu_ab = 2'($urandom);
                    cpu_dout = 8'($urandom);
                    step();
                    cs = 1'b0;
                    cpu_cen = 1'b1;
                end else begin
                    step();
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
